wb_dcache_flush_ctrl: RTL and testbench

WB_DCACHE_FLUSH_CTRL -- requirements
Module: wb_dcache_flush_ctrl

---
 rtl/wb_dcache_flush_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_wb_dcache_flush_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// wb_dcache_flush_ctrl
//
// Walks every set of a write-back data cache. For each set it reads the
// per-way valid/dirty metadata, writes back every valid+dirty line (lowest way
// first), then issues a single metadata update that clears the dirty bits of
// the lines it wrote back and, when INVALIDATE_ON_FLUSH is set, clears the
// valid bits of every line that was valid. When the last set is finished it
// pulses flush_ack_o for one cycle.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  flush request level, looked at only while idle
//   flush_ack_o              one-cycle pulse when the whole walk is done
//   busy_o                   high whenever a walk is in progress
//   tag_req_o / tag_gnt_i    metadata read handshake for set tag_set_o;
//                            tag_valid_i/tag_dirty_i valid the cycle after grant
//   tag_set_o                set index used by read, write-back and update
//   wb_req_o / wb_ack_i      write-back handshake for line (tag_set_o, wb_way_o)
//   upd_req_o / upd_gnt_i    metadata update handshake, masks in
//                            upd_clr_dirty_o / upd_clr_valid_o
// ---------------------------------------------------------------------------
module wb_dcache_flush_ctrl #(
  parameter int unsigned NR_SETS             = 256,
  parameter int unsigned NR_WAYS             = 8,
  parameter bit          INVALIDATE_ON_FLUSH = 1'b0,
  localparam int unsigned SW = $clog2(NR_SETS),
  localparam int unsigned WW = $clog2(NR_WAYS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               flush_ack_o,
  output logic               busy_o,
  output logic               tag_req_o,
  input  logic               tag_gnt_i,
  output logic [SW-1:0]      tag_set_o,
  input  logic [NR_WAYS-1:0] tag_valid_i,
  input  logic [NR_WAYS-1:0] tag_dirty_i,
  output logic               wb_req_o,
  output logic [WW-1:0]      wb_way_o,
  input  logic               wb_ack_i,
  output logic               upd_req_o,
  output logic [NR_WAYS-1:0] upd_clr_dirty_o,
  output logic [NR_WAYS-1:0] upd_clr_valid_o,
  input  logic               upd_gnt_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_WB    = 3'd3,
    S_UPD   = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [SW-1:0] LAST_SET = SW'(NR_SETS - 1);

  state_e             state_q, state_d;
  logic [SW-1:0]      set_q, set_d;
  logic [NR_WAYS-1:0] pend_q, pend_d;    // lines still waiting for write-back
  logic [NR_WAYS-1:0] dirty_q, dirty_d;  // lines written back in this set
  logic [NR_WAYS-1:0] valid_q, valid_d;  // valid snapshot taken in CHECK

  // Lowest pending way: descending scan so the lowest set bit wins.
  logic [WW-1:0]      way_sel;
  logic [NR_WAYS-1:0] way_oh;

  always_comb begin
    way_sel = '0;
    way_oh  = '0;
    for (int i = NR_WAYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        way_sel    = WW'(i);
        way_oh     = '0;
        way_oh[i]  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      pend_q  <= '0;
      dirty_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      pend_q  <= pend_d;
      dirty_q <= dirty_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    pend_d  = pend_q;
    dirty_d = dirty_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_READ;
          set_d   = '0;
        end
      end
      S_READ: begin
        if (tag_gnt_i) state_d = S_CHECK;
      end
      S_CHECK: begin
        // Metadata for tag_set_o is presented this cycle (one after grant).
        pend_d  = tag_valid_i & tag_dirty_i;
        dirty_d = tag_valid_i & tag_dirty_i;
        valid_d = tag_valid_i;
        if ((tag_valid_i & tag_dirty_i) != '0) begin
          state_d = S_WB;
        end else if (INVALIDATE_ON_FLUSH && (tag_valid_i != '0)) begin
          state_d = S_UPD;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WB: begin
        if (wb_ack_i) begin
          pend_d = pend_q & ~way_oh;
          if (pend_d == '0) state_d = S_UPD;
        end
      end
      S_UPD: begin
        if (upd_gnt_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (set_q == LAST_SET) begin
          set_d   = '0;
          state_d = S_DONE;
        end else begin
          set_d   = set_q + SW'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are Moore-style so every request is stable for the whole
  // handshake and nothing leaks out of its own state.
  always_comb begin
    tag_req_o       = 1'b0;
    wb_req_o        = 1'b0;
    wb_way_o        = '0;
    upd_req_o       = 1'b0;
    upd_clr_dirty_o = '0;
    upd_clr_valid_o = '0;
    flush_ack_o     = 1'b0;
    busy_o          = (state_q != S_IDLE);
    unique case (state_q)
      S_READ: tag_req_o = 1'b1;
      S_WB: begin
        wb_req_o = 1'b1;
        wb_way_o = way_sel;
      end
      S_UPD: begin
        upd_req_o       = 1'b1;
        upd_clr_dirty_o = dirty_q;
        upd_clr_valid_o = INVALIDATE_ON_FLUSH ? valid_q : '0;
      end
      S_DONE: flush_ack_o = 1'b1;
      default: begin
      end
    endcase
  end

  assign tag_set_o = set_q;

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
module tb_wb_dcache_flush_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main DUT (INVALIDATE_ON_FLUSH = 0) ----------------
  logic       rst_n;
  logic       flush;
  logic       flush_ack, busy;
  logic       tag_req, tag_gnt;
  logic [1:0] tag_set;
  logic [7:0] tag_valid, tag_dirty;
  logic       wb_req, wb_ack;
  logic [2:0] wb_way;
  logic       upd_req, upd_gnt;
  logic [7:0] clr_dirty, clr_valid;

  logic [7:0] vmem [4];
  logic [7:0] dmem [4];
  assign tag_valid = vmem[tag_set];
  assign tag_dirty = dmem[tag_set];

  wb_dcache_flush_ctrl #(.NR_SETS(4), .NR_WAYS(8), .INVALIDATE_ON_FLUSH(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_ack_o(flush_ack), .busy_o(busy),
    .tag_req_o(tag_req), .tag_gnt_i(tag_gnt), .tag_set_o(tag_set),
    .tag_valid_i(tag_valid), .tag_dirty_i(tag_dirty),
    .wb_req_o(wb_req), .wb_way_o(wb_way), .wb_ack_i(wb_ack),
    .upd_req_o(upd_req), .upd_clr_dirty_o(clr_dirty), .upd_clr_valid_o(clr_valid),
    .upd_gnt_i(upd_gnt)
  );

  // ---------------- second DUT (INVALIDATE_ON_FLUSH = 1) ----------------
  logic       flush2;
  logic       flush_ack2, busy2;
  logic       tag_req2;
  logic [1:0] tag_set2;
  logic [7:0] tag_valid2, tag_dirty2;
  logic       wb_req2;
  logic [2:0] wb_way2;
  logic       upd_req2;
  logic [7:0] clr_dirty2, clr_valid2;
  logic [7:0] vmem2 [4];
  logic [7:0] dmem2 [4];
  assign tag_valid2 = vmem2[tag_set2];
  assign tag_dirty2 = dmem2[tag_set2];

  wb_dcache_flush_ctrl #(.NR_SETS(4), .NR_WAYS(8), .INVALIDATE_ON_FLUSH(1'b1)) u_inv (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .flush_ack_o(flush_ack2), .busy_o(busy2),
    .tag_req_o(tag_req2), .tag_gnt_i(1'b1), .tag_set_o(tag_set2),
    .tag_valid_i(tag_valid2), .tag_dirty_i(tag_dirty2),
    .wb_req_o(wb_req2), .wb_way_o(wb_way2), .wb_ack_i(1'b1),
    .upd_req_o(upd_req2), .upd_clr_dirty_o(clr_dirty2), .upd_clr_valid_o(clr_valid2),
    .upd_gnt_i(1'b1)
  );

  // ---------------- responder + event logger for main DUT ----------------
  int tag_dly = 0, wb_dly = 0, upd_dly = 0;
  int tcnt, wcnt, ucnt;
  logic [1:0]  rd_q  [$];
  logic [4:0]  wb_q  [$];   // {set, way}
  logic [17:0] upd_q [$];   // {set, clr_dirty, clr_valid}
  int ack_cnt = 0, viol = 0, unstable = 0, ack_long = 0;
  logic       p_tag_req, p_wb_req, p_upd_req, p_ack;
  logic [1:0] p_set;
  logic [2:0] p_way;
  logic [7:0] p_cd;

  always @(negedge clk) begin
    if (!rst_n) begin
      tag_gnt = 1'b0; wb_ack = 1'b0; upd_gnt = 1'b0;
      tcnt = 0; wcnt = 0; ucnt = 0;
      p_tag_req = 1'b0; p_wb_req = 1'b0; p_upd_req = 1'b0; p_ack = 1'b0;
      p_set = '0; p_way = '0; p_cd = '0;
    end else begin
      // stability while a request waits (grant values are those of the last edge)
      if (tag_req && p_tag_req && !tag_gnt && tag_set != p_set) unstable++;
      if (wb_req && p_wb_req && !wb_ack && (wb_way != p_way || tag_set != p_set)) unstable++;
      if (upd_req && p_upd_req && !upd_gnt && clr_dirty != p_cd) unstable++;
      if ((int'(tag_req) + int'(wb_req) + int'(upd_req) + int'(flush_ack)) > 1) viol++;
      if (!upd_req && ((clr_dirty | clr_valid) != 8'h00)) viol++;
      if (flush_ack && p_ack) ack_long++;
      if (flush_ack) ack_cnt++;
      // grants for the coming edge
      if (tag_req) begin tag_gnt = (tcnt >= tag_dly); tcnt = tag_gnt ? 0 : tcnt + 1; end
      else begin tag_gnt = 1'b0; tcnt = 0; end
      if (wb_req) begin wb_ack = (wcnt >= wb_dly); wcnt = wb_ack ? 0 : wcnt + 1; end
      else begin wb_ack = 1'b0; wcnt = 0; end
      if (upd_req) begin upd_gnt = (ucnt >= upd_dly); ucnt = upd_gnt ? 0 : ucnt + 1; end
      else begin upd_gnt = 1'b0; ucnt = 0; end
      if (tag_req && tag_gnt) rd_q.push_back(tag_set);
      if (wb_req && wb_ack) wb_q.push_back({tag_set, wb_way});
      if (upd_req && upd_gnt) upd_q.push_back({tag_set, clr_dirty, clr_valid});
      p_tag_req = tag_req; p_wb_req = wb_req; p_upd_req = upd_req; p_ack = flush_ack;
      p_set = tag_set; p_way = wb_way; p_cd = clr_dirty;
    end
  end

  task automatic clear_logs();
    rd_q.delete(); wb_q.delete(); upd_q.delete();
    ack_cnt = 0; viol = 0; unstable = 0; ack_long = 0;
  endtask

  task automatic set_mem(input logic [7:0] v, input logic [7:0] d);
    for (int i = 0; i < 4; i++) begin vmem[i] = v; dmem[i] = d; end
  endtask

  // Pulse flush for one sampling edge and count cycles until flush_ack.
  task automatic run_walk(output int lat, output bit timed_out);
    lat = 0; timed_out = 1'b0;
    @(negedge clk) flush = 1'b1;
    @(posedge clk) #1 flush = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (flush_ack) break;
      if (lat > 2000) begin timed_out = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; flush2 = 1'b0;
    set_mem(8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin vmem2[i] = 8'h00; dmem2[i] = 8'h00; end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({tag_req, wb_req, upd_req, flush_ack} !== 4'b0000) begin
      bad++; $display("FAIL reset_reqs: got %b want 0000", {tag_req, wb_req, upd_req, flush_ack}); end
    total++; if ({tag_set, wb_way} !== 5'd0) begin
      bad++; $display("FAIL reset_idx: got %h want 00", {tag_set, wb_way}); end
    total++; if ({clr_dirty, clr_valid} !== 16'h0000) begin
      bad++; $display("FAIL reset_masks: got %h want 0000", {clr_dirty, clr_valid}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("txn reset: busy=%b tag_set=%0d", busy, tag_set);
  endtask

  task automatic test_clean_walk();
    int lat; bit to;
    tag_dly = 0; wb_dly = 0; upd_dly = 0;
    set_mem(8'hFF, 8'h00);
    clear_logs();
    run_walk(lat, to);
    $display("txn clean_walk: latency=%0d reads=%0d wbs=%0d upds=%0d", lat, rd_q.size(), wb_q.size(), upd_q.size());
    total++; if (to !== 1'b0) begin bad++; $display("FAIL clean_timeout: got %b want 0", to); end
    total++; if (lat !== 13) begin bad++; $display("FAIL clean_latency: got %0d want 13", lat); end
    total++; if (rd_q.size() !== 4) begin bad++; $display("FAIL clean_nreads: got %0d want 4", rd_q.size()); end
    else begin
      total++; if ({rd_q[3], rd_q[2], rd_q[1], rd_q[0]} !== 8'b11_10_01_00) begin
        bad++; $display("FAIL clean_order: got %b want 11100100", {rd_q[3], rd_q[2], rd_q[1], rd_q[0]}); end
    end
    total++; if (wb_q.size() + upd_q.size() !== 0) begin
      bad++; $display("FAIL clean_no_wb_upd: got %0d want 0", wb_q.size() + upd_q.size()); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL clean_ack_cnt: got %0d want 1", ack_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clean_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_dirty_set();
    int lat; bit to;
    set_mem(8'hFF, 8'h00);
    dmem[2] = 8'h21;
    clear_logs();
    run_walk(lat, to);
    $display("txn dirty_set: latency=%0d wbs=%0d upds=%0d", lat, wb_q.size(), upd_q.size());
    total++; if (lat !== 16) begin bad++; $display("FAIL dirty_latency: got %0d want 16", lat); end
    total++; if (wb_q.size() !== 2) begin bad++; $display("FAIL dirty_nwb: got %0d want 2", wb_q.size()); end
    else begin
      total++; if ({wb_q[0], wb_q[1]} !== {2'd2, 3'd0, 2'd2, 3'd5}) begin
        bad++; $display("FAIL dirty_ways: got %h want %h", {wb_q[0], wb_q[1]}, {2'd2, 3'd0, 2'd2, 3'd5}); end
    end
    total++; if (upd_q.size() !== 1) begin bad++; $display("FAIL dirty_nupd: got %0d want 1", upd_q.size()); end
    else begin
      total++; if (upd_q[0] !== {2'd2, 8'h21, 8'h00}) begin
        bad++; $display("FAIL dirty_upd_masks: got %h want %h", upd_q[0], {2'd2, 8'h21, 8'h00}); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL dirty_exclusive: got %0d want 0", viol); end
  endtask

  task automatic test_delays();
    int lat; bit to;
    tag_dly = 3; wb_dly = 5; upd_dly = 2;
    set_mem(8'hFF, 8'h00);
    dmem[1] = 8'h82;
    clear_logs();
    run_walk(lat, to);
    $display("txn delays: latency=%0d wbs=%0d unstable=%0d", lat, wb_q.size(), unstable);
    total++; if (lat !== 40) begin bad++; $display("FAIL delay_latency: got %0d want 40", lat); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL delay_stable: got %0d want 0", unstable); end
    total++; if (wb_q.size() !== 2) begin bad++; $display("FAIL delay_nwb: got %0d want 2", wb_q.size()); end
    else begin
      total++; if ({wb_q[0], wb_q[1]} !== {2'd1, 3'd1, 2'd1, 3'd7}) begin
        bad++; $display("FAIL delay_ways: got %h want %h", {wb_q[0], wb_q[1]}, {2'd1, 3'd1, 2'd1, 3'd7}); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL delay_exclusive: got %0d want 0", viol); end
    tag_dly = 0; wb_dly = 0; upd_dly = 0;
  endtask

  task automatic test_reset_mid_walk();
    int n; int lat; bit to;
    tag_dly = 0; wb_dly = 5; upd_dly = 0;
    set_mem(8'hFF, 8'h00);
    dmem[1] = 8'h82;
    clear_logs();
    @(negedge clk) flush = 1'b1;
    @(posedge clk) #1 flush = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (wb_req && tag_set == 2'd1) break;
      if (n > 200) break;
    end
    total++; if (n > 200) begin bad++; $display("FAIL midrst_reach_wb: got timeout want wb at set 1"); end
    rst_n = 1'b0;
    @(negedge clk);
    $display("txn reset_mid_walk: busy=%b reqs=%b set=%0d", busy, {tag_req, wb_req, upd_req, flush_ack}, tag_set);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if ({tag_req, wb_req, upd_req, flush_ack, tag_set, wb_way, clr_dirty, clr_valid} !== 25'd0) begin
      bad++; $display("FAIL midrst_outputs: got %h want 0",
                      {tag_req, wb_req, upd_req, flush_ack, tag_set, wb_way, clr_dirty, clr_valid}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (ack_cnt !== 0) begin bad++; $display("FAIL midrst_no_ack: got %0d want 0", ack_cnt); end
    wb_dly = 0;
    set_mem(8'hFF, 8'h00);
    clear_logs();
    run_walk(lat, to);
    $display("txn restart: latency=%0d first_set=%0d", lat, rd_q.size() > 0 ? int'(rd_q[0]) : -1);
    total++; if (rd_q.size() !== 4) begin bad++; $display("FAIL restart_nreads: got %0d want 4", rd_q.size()); end
    else begin
      total++; if (rd_q[0] !== 2'd0) begin bad++; $display("FAIL restart_first_set: got %0d want 0", rd_q[0]); end
    end
    total++; if (lat !== 13) begin bad++; $display("FAIL restart_latency: got %0d want 13", lat); end
  endtask

  task automatic test_back_to_back();
    int n, k, t1, t2;
    tag_dly = 0; wb_dly = 0; upd_dly = 0;
    set_mem(8'hFF, 8'h00);
    clear_logs();
    n = 0; k = 0; t1 = 0; t2 = 0;
    @(negedge clk) flush = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (flush_ack) begin
        k++;
        if (k == 1) t1 = n;
        if (k == 2) t2 = n;
        if (k == 3) begin flush = 1'b0; break; end
      end
      if (n > 500) begin flush = 1'b0; break; end
    end
    repeat (20) @(negedge clk);
    $display("txn back_to_back: acks=%0d gap=%0d reads=%0d", ack_cnt, t2 - t1, rd_q.size());
    total++; if (k !== 3) begin bad++; $display("FAIL b2b_walks: got %0d want 3", k); end
    total++; if (t2 - t1 !== 14) begin bad++; $display("FAIL b2b_gap: got %0d want 14", t2 - t1); end
    total++; if (ack_cnt !== 3) begin bad++; $display("FAIL b2b_ack_cnt: got %0d want 3", ack_cnt); end
    total++; if (ack_long !== 0) begin bad++; $display("FAIL b2b_ack_width: got %0d want 0", ack_long); end
    total++; if (rd_q.size() !== 12) begin bad++; $display("FAIL b2b_reads: got %0d want 12", rd_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_invalidate();
    int n, wbc, upc;
    logic [2:0]  way_seen;
    logic [17:0] u0, u1;
    for (int i = 0; i < 4; i++) begin vmem2[i] = 8'h00; dmem2[i] = 8'h00; end
    vmem2[1] = 8'h0C;
    vmem2[3] = 8'h30; dmem2[3] = 8'h10;
    n = 0; wbc = 0; upc = 0; way_seen = '0; u0 = '0; u1 = '0;
    @(negedge clk) flush2 = 1'b1;
    @(posedge clk) #1 flush2 = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (wb_req2) begin wbc++; way_seen = wb_way2; end
      if (upd_req2) begin
        if (upc == 0) u0 = {tag_set2, clr_dirty2, clr_valid2};
        else u1 = {tag_set2, clr_dirty2, clr_valid2};
        upc++;
      end
      if (flush_ack2) break;
      if (n > 500) break;
    end
    @(negedge clk);
    $display("txn invalidate: latency=%0d wbs=%0d upds=%0d upd0=%h upd1=%h", n, wbc, upc, u0, u1);
    total++; if (n !== 16) begin bad++; $display("FAIL inv_latency: got %0d want 16", n); end
    total++; if ({wbc, way_seen} !== {32'd1, 3'd4}) begin
      bad++; $display("FAIL inv_wb: got count %0d way %0d want count 1 way 4", wbc, way_seen); end
    total++; if (upc !== 2) begin bad++; $display("FAIL inv_nupd: got %0d want 2", upc); end
    total++; if (u0 !== {2'd1, 8'h00, 8'h0C}) begin
      bad++; $display("FAIL inv_upd_clean: got %h want %h", u0, {2'd1, 8'h00, 8'h0C}); end
    total++; if (u1 !== {2'd3, 8'h10, 8'h30}) begin
      bad++; $display("FAIL inv_upd_dirty: got %h want %h", u1, {2'd3, 8'h10, 8'h30}); end
  endtask

  initial begin
    test_reset();
    test_clean_walk();
    test_dirty_set();
    test_delays();
    test_reset_mid_walk();
    test_back_to_back();
    test_invalidate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
